// File: rtl/munoc_wdsz_pkg.sv
// Shared definitions for the W-channel downsizer: FSM encoding, AXI size codes
// and the byte-mask helper. Optional feature macro: MUNOC_WDOWNSIZER_WLAST_CHECK_EN.
package munoc_wdsz_pkg;

  localparam int ST_W = 2;
  localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [ST_W-1:0] ST_PASS  = 2'd1;
  localparam logic [ST_W-1:0] ST_SPLIT = 2'd2;

  localparam int AXI_SIZE_W = 3;
  localparam logic [AXI_SIZE_W-1:0] AXI_SIZE_1B   = 3'd0;
  localparam logic [AXI_SIZE_W-1:0] AXI_SIZE_2B   = 3'd1;
  localparam logic [AXI_SIZE_W-1:0] AXI_SIZE_4B   = 3'd2;
  localparam logic [AXI_SIZE_W-1:0] AXI_SIZE_8B   = 3'd3;
  localparam logic [AXI_SIZE_W-1:0] AXI_SIZE_16B  = 3'd4;
  localparam logic [AXI_SIZE_W-1:0] AXI_SIZE_32B  = 3'd5;
  localparam logic [AXI_SIZE_W-1:0] AXI_SIZE_64B  = 3'd6;
  localparam logic [AXI_SIZE_W-1:0] AXI_SIZE_128B = 3'd7;

  localparam int MASK_W = 128;

  // 2^size ones at bit 0, clamped to one full narrow beat (2^nsize bytes).
  function automatic logic [MASK_W-1:0] size_to_mask(input logic [AXI_SIZE_W-1:0] size,
                                                     input int nsize);
    int eff;
    eff = (int'(size) > nsize) ? nsize : int'(size);
    size_to_mask = '0;
    for (int i = 0; i < MASK_W; i++) begin
      if (i < (1 << eff)) size_to_mask[i] = 1'b1;
    end
  endfunction

endpackage

// File: rtl/munoc_wdsz_lane_sel.sv
// Lane multiplexer: picks lane idx out of a bus of NUM_LANE lanes of BW_LANE bits.
// Used for both data and strobes of the W-channel downsizer.
module munoc_wdsz_lane_sel
  import munoc_wdsz_pkg::*;
#(
  parameter int BW_LANE  = 32,
  parameter int NUM_LANE = 4,
  localparam int BW_IDX  = (NUM_LANE > 1) ? $clog2(NUM_LANE) : 1
) (
  input  logic [BW_LANE*NUM_LANE-1:0] bus,
  input  logic [BW_IDX-1:0]           idx,
  output logic [BW_LANE-1:0]          lane
);

  always_comb begin
    lane = '0;
    for (int i = 0; i < NUM_LANE; i++) begin
      if (idx == BW_IDX'(i)) lane = bus[i*BW_LANE +: BW_LANE];
    end
  end

endmodule

// File: rtl/munoc_wdata_downsizer_v2.sv
// AXI W-channel width downsizer: splits wide beats into narrow beats per burst command.
// Define MUNOC_WDOWNSIZER_WLAST_CHECK_EN to add the sticky protocol_error output.
//
// Handshake rule on every interface: a transfer happens in a cycle where valid and
// ready are both high; valid never depends on ready, and payload is held while stalled.
module munoc_wdata_downsizer_v2
  import munoc_wdsz_pkg::*;
#(
  parameter int BW_WIDE_DATA   = 128,
  parameter int BW_NARROW_DATA = 32,
  parameter int BW_LEN         = 8,
  localparam int BW_OFFSET     = $clog2(BW_WIDE_DATA/8)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [BW_OFFSET-1:0]        cmd_offset,
  input  logic [AXI_SIZE_W-1:0]       cmd_size,
  input  logic [BW_LEN-1:0]           cmd_len,
  input  logic                        wide_wvalid,
  output logic                        wide_wready,
  input  logic [BW_WIDE_DATA-1:0]     wide_wdata,
  input  logic [BW_WIDE_DATA/8-1:0]   wide_wstrb,
  input  logic                        wide_wlast,
  output logic                        narrow_wvalid,
  input  logic                        narrow_wready,
  output logic [BW_NARROW_DATA-1:0]   narrow_wdata,
  output logic [BW_NARROW_DATA/8-1:0] narrow_wstrb,
  output logic                        narrow_wlast,
  output logic                        busy
`ifdef MUNOC_WDOWNSIZER_WLAST_CHECK_EN
  ,
  output logic                        protocol_error
`endif
);

  localparam int WB       = BW_WIDE_DATA / 8;
  localparam int NB       = BW_NARROW_DATA / 8;
  localparam int NSIZE    = $clog2(NB);
  localparam int NUM_LANE = WB / NB;
  localparam int BW_LIDX  = $clog2(NUM_LANE);

  logic [ST_W-1:0]       state;
  logic [BW_OFFSET-1:0]  cur_addr;
  logic [AXI_SIZE_W-1:0] size_q;
  logic [BW_LEN-1:0]     len_q;
  logic [BW_LEN-1:0]     beat_cnt;
  logic [BW_LIDX-1:0]    sub_idx;

  logic [BW_OFFSET-1:0]  size_bytes;
  logic [BW_OFFSET-1:0]  win_base;
  logic [BW_OFFSET-1:0]  lo_aligned;
  logic [AXI_SIZE_W-1:0] split_shift;
  logic [BW_LIDX-1:0]    win_mask;
  logic [BW_LIDX-1:0]    lane_idx;
  logic [NB-1:0]         pass_mask;
  logic [NB-1:0]         lane_strb;
  logic                  last_lane;
  logic                  last_beat;
  logic                  narrow_hs;

  // A full-width size makes size_bytes wrap to 0, so the address stays put.
  assign size_bytes  = BW_OFFSET'(32'd1 << size_q);
  assign win_base    = cur_addr & ~BW_OFFSET'((32'd1 << size_q) - 32'd1);
  assign split_shift = size_q - AXI_SIZE_W'(NSIZE);
  assign win_mask    = BW_LIDX'((32'd1 << split_shift) - 32'd1);
  assign last_lane   = (state == ST_SPLIT) && ((sub_idx & win_mask) == win_mask);
  assign last_beat   = (beat_cnt == len_q);
  assign busy        = (state != ST_IDLE);
  assign narrow_hs   = narrow_wvalid & narrow_wready;

  // Sub-beat accesses only enable the bytes of the current size-aligned element.
  assign lo_aligned = cur_addr & BW_OFFSET'(NB - 1) & ~BW_OFFSET'((32'd1 << size_q) - 32'd1);
  assign pass_mask  = NB'(size_to_mask(size_q, NSIZE) << lo_aligned);

  assign lane_idx = (state == ST_PASS) ? cur_addr[BW_OFFSET-1:NSIZE] : sub_idx;

  munoc_wdsz_lane_sel #(
    .BW_LANE  (BW_NARROW_DATA),
    .NUM_LANE (NUM_LANE)
  ) u_data_sel (
    .bus  (wide_wdata),
    .idx  (lane_idx),
    .lane (narrow_wdata)
  );

  munoc_wdsz_lane_sel #(
    .BW_LANE  (NB),
    .NUM_LANE (NUM_LANE)
  ) u_strb_sel (
    .bus  (wide_wstrb),
    .idx  (lane_idx),
    .lane (lane_strb)
  );

  always_comb begin
    cmd_ready     = (state == ST_IDLE);
    narrow_wvalid = 1'b0;
    wide_wready   = 1'b0;
    narrow_wstrb  = '0;
    narrow_wlast  = 1'b0;
    case (state)
      ST_PASS: begin
        narrow_wvalid = wide_wvalid;
        wide_wready   = narrow_wready;
        narrow_wstrb  = lane_strb & pass_mask;
        narrow_wlast  = last_beat;
      end
      ST_SPLIT: begin
        narrow_wvalid = wide_wvalid;
        wide_wready   = narrow_wready & last_lane;
        narrow_wstrb  = lane_strb;
        narrow_wlast  = last_beat & last_lane;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cur_addr <= '0;
      size_q   <= '0;
      len_q    <= '0;
      beat_cnt <= '0;
      sub_idx  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            size_q   <= cmd_size;
            len_q    <= cmd_len;
            cur_addr <= cmd_offset;
            beat_cnt <= '0;
            sub_idx  <= cmd_offset[BW_OFFSET-1:NSIZE];
            state    <= (cmd_size <= AXI_SIZE_W'(NSIZE)) ? ST_PASS : ST_SPLIT;
          end
        end
        ST_PASS: begin
          if (narrow_hs) begin
            cur_addr <= cur_addr + size_bytes;
            beat_cnt <= beat_cnt + BW_LEN'(1);
            if (last_beat) state <= ST_IDLE;
          end
        end
        ST_SPLIT: begin
          // Windows are contiguous, so the next window's first lane is always sub_idx+1.
          if (narrow_hs) begin
            sub_idx <= sub_idx + BW_LIDX'(1);
            if (last_lane) begin
              cur_addr <= win_base + size_bytes;
              beat_cnt <= beat_cnt + BW_LEN'(1);
              if (last_beat) state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef MUNOC_WDOWNSIZER_WLAST_CHECK_EN
  logic wide_hs;
  assign wide_hs = wide_wvalid & wide_wready;

  always_ff @(posedge clk) begin
    if (rst) begin
      protocol_error <= 1'b0;
    end else if (wide_hs && (wide_wlast != last_beat)) begin
      protocol_error <= 1'b1;
    end
  end
`else
  logic unused_wlast;
  assign unused_wlast = wide_wlast;
`endif

endmodule

// File: tb/tb_munoc_wdata_downsizer_v2.sv
// Directed bench for munoc_wdata_downsizer_v2: 128->32 and 64->32 instances,
// table-driven bursts plus stall, reset and wlast-check sequences.
module tb_munoc_wdata_downsizer_v2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 128 -> 32 instance
  logic         cmd_valid, cmd_ready;
  logic [3:0]   cmd_offset;
  logic [2:0]   cmd_size;
  logic [7:0]   cmd_len;
  logic         wide_wvalid, wide_wready, wide_wlast;
  logic [127:0] wide_wdata;
  logic [15:0]  wide_wstrb;
  logic         narrow_wvalid, narrow_wready, narrow_wlast, busy;
  logic [31:0]  narrow_wdata;
  logic [3:0]   narrow_wstrb;
`ifdef MUNOC_WDOWNSIZER_WLAST_CHECK_EN
  logic         protocol_error;
  logic         protocol_error_b;
`endif

  // 64 -> 32 instance
  logic         cmd_valid_b, cmd_ready_b;
  logic [2:0]   cmd_offset_b;
  logic [2:0]   cmd_size_b;
  logic [7:0]   cmd_len_b;
  logic         wide_wvalid_b, wide_wready_b, wide_wlast_b;
  logic [63:0]  wide_wdata_b;
  logic [7:0]   wide_wstrb_b;
  logic         narrow_wvalid_b, narrow_wready_b, narrow_wlast_b, busy_b;
  logic [31:0]  narrow_wdata_b;
  logic [3:0]   narrow_wstrb_b;

  munoc_wdata_downsizer_v2 #(.BW_WIDE_DATA(128), .BW_NARROW_DATA(32), .BW_LEN(8)) u_dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_offset(cmd_offset),
    .cmd_size(cmd_size), .cmd_len(cmd_len),
    .wide_wvalid(wide_wvalid), .wide_wready(wide_wready), .wide_wdata(wide_wdata),
    .wide_wstrb(wide_wstrb), .wide_wlast(wide_wlast),
    .narrow_wvalid(narrow_wvalid), .narrow_wready(narrow_wready), .narrow_wdata(narrow_wdata),
    .narrow_wstrb(narrow_wstrb), .narrow_wlast(narrow_wlast), .busy(busy)
`ifdef MUNOC_WDOWNSIZER_WLAST_CHECK_EN
    , .protocol_error(protocol_error)
`endif
  );

  munoc_wdata_downsizer_v2 #(.BW_WIDE_DATA(64), .BW_NARROW_DATA(32), .BW_LEN(8)) u_dut_b (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_offset(cmd_offset_b),
    .cmd_size(cmd_size_b), .cmd_len(cmd_len_b),
    .wide_wvalid(wide_wvalid_b), .wide_wready(wide_wready_b), .wide_wdata(wide_wdata_b),
    .wide_wstrb(wide_wstrb_b), .wide_wlast(wide_wlast_b),
    .narrow_wvalid(narrow_wvalid_b), .narrow_wready(narrow_wready_b), .narrow_wdata(narrow_wdata_b),
    .narrow_wstrb(narrow_wstrb_b), .narrow_wlast(narrow_wlast_b), .busy(busy_b)
`ifdef MUNOC_WDOWNSIZER_WLAST_CHECK_EN
    , .protocol_error(protocol_error_b)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lv(input int k, input int j);
    return 32'hC0DE0000 | 32'(k << 4) | 32'(j);
  endfunction

  function automatic logic [127:0] wword(input int k);
    logic [127:0] w;
    for (int j = 0; j < 4; j++) w[j*32 +: 32] = lv(k, j);
    return w;
  endfunction

  typedef struct {
    logic        first;
    logic [3:0]  offset;
    logic [2:0]  size;
    logic [7:0]  len;
    int          widx;
    logic [15:0] wstrb;
    logic        wlast;
    logic [31:0] e_data;
    logic [3:0]  e_strb;
    logic        e_last;
    logic        e_wready;
  } vec_t;

  function automatic vec_t mk(input logic first, input logic [3:0] offset, input logic [2:0] size,
                              input logic [7:0] len, input int widx, input logic [15:0] wstrb,
                              input logic wlast, input logic [31:0] e_data, input logic [3:0] e_strb,
                              input logic e_last, input logic e_wready);
    vec_t v;
    v.first = first; v.offset = offset; v.size = size; v.len = len; v.widx = widx;
    v.wstrb = wstrb; v.wlast = wlast; v.e_data = e_data; v.e_strb = e_strb;
    v.e_last = e_last; v.e_wready = e_wready;
    return v;
  endfunction

  task automatic issue_cmd(input logic [3:0] off, input logic [2:0] sz, input logic [7:0] ln);
    @(negedge clk);
    wide_wvalid = 1'b0;
    cmd_valid   = 1'b1;
    cmd_offset  = off;
    cmd_size    = sz;
    cmd_len     = ln;
    #2;
    chk("cmd_ready_idle", cmd_ready, 1'b1);
    chk("busy_idle", busy, 1'b0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("busy_after_cmd", busy, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vecs[13];
  logic [36:0] exp_q[$];
  logic [3:0]  b_strb[3];

  initial begin
    logic [36:0] exp_e;
    int cyc, widx, whs;
    logic held_v;
    logic [31:0] held_d;

    rst = 1'b1;
    cmd_valid = 0; cmd_offset = 0; cmd_size = 0; cmd_len = 0;
    wide_wvalid = 0; wide_wdata = '0; wide_wstrb = '0; wide_wlast = 0; narrow_wready = 0;
    cmd_valid_b = 0; cmd_offset_b = 0; cmd_size_b = 0; cmd_len_b = 0;
    wide_wvalid_b = 0; wide_wdata_b = '0; wide_wstrb_b = '0; wide_wlast_b = 0; narrow_wready_b = 0;

    // size 2 offset 4 len 3: lanes 1,2,3,0
    vecs[0]  = mk(1, 4'h4, 3'd2, 8'd3, 0, 16'hFFFF, 0, lv(0, 1), 4'hF, 0, 1);
    vecs[1]  = mk(0, 4'h4, 3'd2, 8'd3, 1, 16'hFFFF, 0, lv(1, 2), 4'hF, 0, 1);
    vecs[2]  = mk(0, 4'h4, 3'd2, 8'd3, 2, 16'hFFFF, 0, lv(2, 3), 4'hF, 0, 1);
    vecs[3]  = mk(0, 4'h4, 3'd2, 8'd3, 3, 16'hFFFF, 1, lv(3, 0), 4'hF, 1, 1);
    // size 4 offset 0 len 1: 8 narrow beats, wide_wready on 4th and 8th
    vecs[4]  = mk(1, 4'h0, 3'd4, 8'd1, 4, 16'hFEDC, 0, lv(4, 0), 4'hC, 0, 0);
    vecs[5]  = mk(0, 4'h0, 3'd4, 8'd1, 4, 16'hFEDC, 0, lv(4, 1), 4'hD, 0, 0);
    vecs[6]  = mk(0, 4'h0, 3'd4, 8'd1, 4, 16'hFEDC, 0, lv(4, 2), 4'hE, 0, 0);
    vecs[7]  = mk(0, 4'h0, 3'd4, 8'd1, 4, 16'hFEDC, 0, lv(4, 3), 4'hF, 0, 1);
    vecs[8]  = mk(0, 4'h0, 3'd4, 8'd1, 5, 16'hFEDC, 1, lv(5, 0), 4'hC, 0, 0);
    vecs[9]  = mk(0, 4'h0, 3'd4, 8'd1, 5, 16'hFEDC, 1, lv(5, 1), 4'hD, 0, 0);
    vecs[10] = mk(0, 4'h0, 3'd4, 8'd1, 5, 16'hFEDC, 1, lv(5, 2), 4'hE, 0, 0);
    vecs[11] = mk(0, 4'h0, 3'd4, 8'd1, 5, 16'hFEDC, 1, lv(5, 3), 4'hF, 1, 1);
    // size 3 offset 0xC len 0: one beat on lane 3, window ends immediately
    vecs[12] = mk(1, 4'hC, 3'd3, 8'd0, 6, 16'hFFFF, 1, lv(6, 3), 4'hF, 1, 1);

    b_strb[0] = 4'h2; b_strb[1] = 4'h4; b_strb[2] = 4'h8;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_wide_wready", wide_wready, 1'b0);
    chk("rst_narrow_wvalid", narrow_wvalid, 1'b0);
    chk("rst_narrow_wlast", narrow_wlast, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_busy_b", busy_b, 1'b0);
    chk("rst_cmd_ready_b", cmd_ready_b, 1'b1);
`ifdef MUNOC_WDOWNSIZER_WLAST_CHECK_EN
    chk("rst_perr", protocol_error, 1'b0);
`endif
    rst = 1'b0;

    // Table-driven bursts with narrow_wready held high
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].first) issue_cmd(vecs[i].offset, vecs[i].size, vecs[i].len);
      @(negedge clk);
      wide_wvalid   = 1'b1;
      wide_wdata    = wword(vecs[i].widx);
      wide_wstrb    = vecs[i].wstrb;
      wide_wlast    = vecs[i].wlast;
      narrow_wready = 1'b1;
      #2;
      chk($sformatf("v%0d_valid", i), narrow_wvalid, 1'b1);
      chk($sformatf("v%0d_data", i), narrow_wdata, vecs[i].e_data);
      chk($sformatf("v%0d_strb", i), narrow_wstrb, vecs[i].e_strb);
      chk($sformatf("v%0d_last", i), narrow_wlast, vecs[i].e_last);
      chk($sformatf("v%0d_wready", i), wide_wready, vecs[i].e_wready);
      chk($sformatf("v%0d_cmd_ready", i), cmd_ready, 1'b0);
      @(posedge clk);
    end
    @(negedge clk);
    wide_wvalid = 1'b0;
    #2;
    chk("table_end_busy", busy, 1'b0);
    chk("table_end_cmd_ready", cmd_ready, 1'b1);

    // 64 -> 32, size 0 offset 5 len 2: byte strobes walk across lane 1
    @(negedge clk);
    cmd_valid_b = 1'b1; cmd_offset_b = 3'd5; cmd_size_b = 3'd0; cmd_len_b = 8'd2;
    #2;
    chk("b_cmd_ready", cmd_ready_b, 1'b1);
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmd_valid_b     = 1'b0;
      wide_wvalid_b   = 1'b1;
      wide_wdata_b    = {lv(10 + i, 1), lv(10 + i, 0)};
      wide_wstrb_b    = 8'hFF;
      wide_wlast_b    = (i == 2);
      narrow_wready_b = 1'b1;
      #2;
      chk($sformatf("b%0d_data", i), narrow_wdata_b, lv(10 + i, 1));
      chk($sformatf("b%0d_strb", i), narrow_wstrb_b, b_strb[i]);
      chk($sformatf("b%0d_last", i), narrow_wlast_b, (i == 2));
      chk($sformatf("b%0d_wready", i), wide_wready_b, 1'b1);
      @(posedge clk);
    end
    @(negedge clk);
    wide_wvalid_b = 1'b0;
    #2;
    chk("b_end_busy", busy_b, 1'b0);

    // size 4 burst under random narrow stalls, scoreboarded
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 4; j++)
        exp_q.push_back({lv(7 + k, j), 4'(4'hC + j), (k == 1 && j == 3)});
    issue_cmd(4'h0, 3'd4, 8'd1);
    cyc = 0; widx = 0; whs = 0; held_v = 1'b0; held_d = '0;
    while (exp_q.size() > 0 && cyc < 300) begin
      @(negedge clk);
      wide_wvalid   = 1'b1;
      wide_wdata    = wword(7 + widx);
      wide_wstrb    = 16'hFEDC;
      wide_wlast    = (widx == 1);
      narrow_wready = ($urandom_range(0, 99) >= 30);
      #2;
      if (held_v) chk("stall_hold", narrow_wdata, held_d);
      if (narrow_wvalid && narrow_wready) begin
        exp_e = exp_q.pop_front();
        chk("stall_beat", {narrow_wdata, narrow_wstrb, narrow_wlast}, exp_e);
        held_v = 1'b0;
      end else begin
        held_v = narrow_wvalid;
        held_d = narrow_wdata;
      end
      if (wide_wvalid && wide_wready) begin
        widx++;
        whs++;
      end
      @(posedge clk);
      cyc++;
    end
    chk("stall_drain", exp_q.size(), 0);
    chk("stall_wide_hs", whs, 2);
    @(negedge clk);
    wide_wvalid = 1'b0;
    narrow_wready = 1'b1;
    #2;
    chk("stall_end_busy", busy, 1'b0);

    // Reset in the middle of a split burst
    issue_cmd(4'h0, 3'd4, 8'd1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      wide_wvalid = 1'b1; wide_wdata = wword(12); wide_wstrb = 16'hFFFF; wide_wlast = 1'b0;
      narrow_wready = 1'b1;
      #2;
      chk($sformatf("mid_data%0d", i), narrow_wdata, lv(12, i));
      @(posedge clk);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_wvalid", narrow_wvalid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_cmd_ready", cmd_ready, 1'b1);
    chk("mid_rst_wready", wide_wready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    wide_wvalid = 1'b0;

`ifdef MUNOC_WDOWNSIZER_WLAST_CHECK_EN
    // wide_wlast asserted early on beat 0 of a 2-beat burst
    chk("perr_before", protocol_error, 1'b0);
    issue_cmd(4'h0, 3'd2, 8'd1);
    @(negedge clk);
    wide_wvalid = 1'b1; wide_wdata = wword(20); wide_wstrb = 16'hFFFF; wide_wlast = 1'b1;
    narrow_wready = 1'b1;
    #2;
    chk("perr_not_yet", protocol_error, 1'b0);
    @(posedge clk);
    @(negedge clk);
    wide_wdata = wword(21);
    #2;
    chk("perr_set", protocol_error, 1'b1);
    @(posedge clk);
    @(negedge clk);
    wide_wvalid = 1'b0;
    #2;
    chk("perr_sticky", protocol_error, 1'b1);
    chk("perr_burst_done", busy, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
